// File: rtl/character_buffer_register_file.sv
// 32 x 8 flip-flop register file for the PS/2 character buffer: one write port, two combinational read ports.
// Optional write-to-read forwarding on both ports when CHARBUF_WRITE_BYPASS_EN is defined.
module character_buffer_register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] select_a,
    input  logic [ADDR_WIDTH-1:0] select_b,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] entry [DEPTH];
    logic [DATA_WIDTH-1:0] stored_a;
    logic [DATA_WIDTH-1:0] stored_b;

    // Reset wins over a coincident write; the whole buffer is discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry <= '{default: '0};
        end else if (write) begin
            entry[address] <= data_in;
        end
    end

    assign stored_a = entry[select_a];
    assign stored_b = entry[select_b];

`ifdef CHARBUF_WRITE_BYPASS_EN
    logic write_live;

    assign write_live = write && !reset;

    always_comb begin
        out_a = stored_a;
        out_b = stored_b;
        if (write_live && (select_a == address)) begin
            out_a = data_in;
        end
        if (write_live && (select_b == address)) begin
            out_b = data_in;
        end
    end
`else
    assign out_a = stored_a;
    assign out_b = stored_b;
`endif

endmodule

// File: tb/tb_character_buffer_register_file.sv
// Scoreboard bench for character_buffer_register_file: the driver queues expected reads,
// the monitor samples out_a/out_b on the falling edge and compares.
module tb_character_buffer_register_file;

    logic       clock = 1'b0;
    logic       reset;
    logic       write;
    logic [4:0] address;
    logic [7:0] data_in;
    logic [4:0] select_a;
    logic [4:0] select_b;
    logic [7:0] out_a;
    logic [7:0] out_b;

    character_buffer_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .write    (write),
        .address  (address),
        .data_in  (data_in),
        .select_a (select_a),
        .select_b (select_b),
        .out_a    (out_a),
        .out_b    (out_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         port_b;
        logic [7:0] exp;
        string      tag;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef CHARBUF_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Inputs only change 1 time unit after a rising edge, so the falling edge sees settled reads.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [7:0] act;
            c = sb.pop_front();
            act = c.port_b ? out_b : out_a;
            n_checks++;
            if (act === c.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s port_%s got %02h expected %02h", c.tag, c.port_b ? "b" : "a", act, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_a(input logic [7:0] v, input string tag);
        chk_t c;
        c.port_b = 1'b0;
        c.exp    = v;
        c.tag    = tag;
        sb.push_back(c);
    endtask

    task automatic expect_b(input logic [7:0] v, input string tag);
        chk_t c;
        c.port_b = 1'b1;
        c.exp    = v;
        c.tag    = tag;
        sb.push_back(c);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        write   = 1'b1;
        address = a;
        data_in = d;
        step();
        write   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        write    = 1'b0;
        address  = '0;
        data_in  = '0;
        select_a = '0;
        select_b = '0;
        step();
        step();
        reset = 1'b0;

        // Reset clear
        do_write(5'd0, 8'hA5);
        do_write(5'd31, 8'hA5);
        select_a = 5'd0;
        select_b = 5'd31;
        expect_a(8'hA5, "pre_reset_e0");
        expect_b(8'hA5, "pre_reset_e31");
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            select_a = 5'(i);
            select_b = 5'(31 - i);
            expect_a(8'h00, "reset_clear");
            expect_b(8'h00, "reset_clear");
            step();
        end

        // Write/read all
        for (int i = 0; i < 32; i++) begin
            do_write(5'(i), 8'(i) ^ 8'h5A);
        end
        for (int i = 0; i < 32; i++) begin
            select_a = 5'(i);
            select_b = 5'(31 - i);
            expect_a(8'(i) ^ 8'h5A, "fill_a_asc");
            expect_b(8'(31 - i) ^ 8'h5A, "fill_b_desc");
            step();
        end

        // Dual port independence
        do_write(5'd3, 8'h1C);
        do_write(5'd17, 8'hF0);
        select_a = 5'd3;
        select_b = 5'd17;
        expect_a(8'h1C, "dual_a3");
        expect_b(8'hF0, "dual_b17");
        step();
        select_a = 5'd17;
        select_b = 5'd3;
        expect_a(8'hF0, "swap_a17");
        expect_b(8'h1C, "swap_b3");
        step();
        select_a = 5'd3;
        select_b = 5'd3;
        expect_a(8'h1C, "same_sel_a");
        expect_b(8'h1C, "same_sel_b");
        step();

        // Write disabled
        do_write(5'd5, 8'h2B);
        address = 5'd5;
        data_in = 8'hFF;
        write   = 1'b0;
        repeat (4) step();
        select_a = 5'd5;
        select_b = 5'd6;
        expect_a(8'h2B, "write_disabled_e5");
        expect_b(8'h6 ^ 8'h5A, "write_disabled_e6");
        step();

        // Reset priority over write
        reset   = 1'b1;
        write   = 1'b1;
        address = 5'd9;
        data_in = 8'h77;
        step();
        reset = 1'b0;
        write = 1'b0;
        select_a = 5'd9;
        select_b = 5'd3;
        expect_a(8'h00, "reset_prio_e9");
        expect_b(8'h00, "reset_prio_e3");
        step();
        do_write(5'd9, 8'h77);
        expect_a(8'h77, "first_write_after_reset");
        step();

        // Read-during-write
        do_write(5'd12, 8'h40);
        select_a = 5'd12;
        select_b = 5'd13;
        write    = 1'b1;
        address  = 5'd12;
        data_in  = 8'h41;
        expect_a(BYPASS ? 8'h41 : 8'h40, "rdw_same_cycle");
        expect_b(8'h00, "rdw_other_port");
        step();
        write = 1'b0;
        expect_a(8'h41, "rdw_after_edge");
        step();

        // Back-to-back writes, last one wins
        do_write(5'd20, 8'h11);
        do_write(5'd20, 8'h22);
        do_write(5'd21, 8'h33);
        select_a = 5'd20;
        select_b = 5'd21;
        expect_a(8'h22, "b2b_last_wins");
        expect_b(8'h33, "b2b_next_addr");
        step();

        step();
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
